// File: rtl/clock_drift_tracker.sv
// clock_drift_tracker: locks onto the faster of two clk-synchronised frame counters and issues drift counts over valid/ready
// Ports:
//   clk, rst_n        block clock, asynchronous active-low reset
//   clock_active      frame clocks stable; low clears everything synchronously
//   tx_cnt_gray       TX frame counter (Gray, already in clk domain)
//   rx_cnt_gray       RX frame counter (Gray, already in clk domain)
//   comp_type         0=UNKNOWN, 1=TX_FAST, 2=RX_FAST
//   comp_cnt/vld/rdy  pending compensation count handshake
//   comp_ovf          sticky: pending count saturated
// Optional (`define COMP_STATS_EN): comp_total running sum of transferred counts, comp_total_ovf sticky on its wrap.
module clock_drift_tracker #(
  parameter int CNT_WIDTH    = 4,
  parameter int MAX_STEP     = 4,
  parameter int LOCK_SAMPLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clock_active,
  input  logic [CNT_WIDTH-1:0] tx_cnt_gray,
  input  logic [CNT_WIDTH-1:0] rx_cnt_gray,
  output logic [1:0]           comp_type,
  output logic [CNT_WIDTH-1:0] comp_cnt,
  output logic                 comp_vld,
  input  logic                 comp_rdy,
  output logic                 comp_ovf
`ifdef COMP_STATS_EN
  ,
  output logic [31:0]          comp_total,
  output logic                 comp_total_ovf
`endif
);
  localparam int LW = $clog2(LOCK_SAMPLES + 1);
  localparam logic [CNT_WIDTH-1:0] ONE  = 1;
  localparam logic [CNT_WIDTH-1:0] STEP = CNT_WIDTH'(MAX_STEP);
  typedef enum logic [1:0] {IDLE, DETECT, LOCK_FAST, LOCK_SLOW} state_t;
  typedef enum logic [1:0] {C_NONE, C_FAST, C_SLOW} cand_t;
  state_t state, state_nxt;
  cand_t prev_cand, cand, cand_nxt;
  logic [LW-1:0] lock_cnt, lock_nxt, lk;
  logic [CNT_WIDTH-1:0] tx, rx, fast_gap, slow_gap, diff, delta, baseline, base_nxt, base, cnt_nxt;
  logic [CNT_WIDTH:0] sum;
  logic dvalid, ovf_nxt;
  // Bit i of the binary value is the XOR of all Gray bits at or above i.
  for (genvar i = 0; i < CNT_WIDTH; i++) begin : g_bin
    assign tx[i] = ^(tx_cnt_gray >> i);
    assign rx[i] = ^(rx_cnt_gray >> i);
  end
  assign fast_gap = tx - (rx + ONE);
  assign slow_gap = rx - (tx + ONE);
  assign cand = (tx == rx) ? C_NONE :
                (fast_gap != '0 && fast_gap < STEP) ? C_FAST :
                (slow_gap != '0 && slow_gap < STEP) ? C_SLOW : C_NONE;
  // prev_cand is C_NONE whenever the counter is cleared, so any fresh candidate reloads to 1.
  assign lk = (cand == C_NONE) ? '0 : (cand == prev_cand) ? LW'(lock_cnt + 1'b1) : LW'(1);
  assign diff = (state == LOCK_SLOW) ? rx - tx : tx - rx;
  assign delta = diff - baseline;
  // Wrapped (negative) drift shows up as a large delta and is rejected by the same window test.
  assign dvalid = (state == LOCK_FAST || state == LOCK_SLOW) && delta != '0 && delta < STEP;
  assign base = (comp_vld && comp_rdy) ? '0 : comp_cnt;
  assign sum = {1'b0, base} + {1'b0, delta};
  assign comp_type = (state == LOCK_FAST) ? 2'd1 : (state == LOCK_SLOW) ? 2'd2 : 2'd0;
  always_comb begin
    state_nxt = state;
    cand_nxt = prev_cand;
    lock_nxt = lock_cnt;
    base_nxt = dvalid ? diff : baseline;
    cnt_nxt = !dvalid ? base : sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    ovf_nxt = comp_ovf | (dvalid & sum[CNT_WIDTH]);
    if (state == IDLE) state_nxt = DETECT;
    if (state == DETECT) begin
      cand_nxt = cand;
      lock_nxt = lk;
      if (lk == LW'(LOCK_SAMPLES)) begin
        state_nxt = (cand == C_FAST) ? LOCK_FAST : LOCK_SLOW;
        base_nxt = (cand == C_FAST) ? tx - rx : rx - tx;
      end
    end
    if (!clock_active) begin
      state_nxt = IDLE;
      cand_nxt = C_NONE;
      lock_nxt = '0;
      base_nxt = '0;
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prev_cand <= C_NONE;
      lock_cnt <= '0;
      baseline <= '0;
      comp_cnt <= '0;
      comp_vld <= 1'b0;
      comp_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      prev_cand <= cand_nxt;
      lock_cnt <= lock_nxt;
      baseline <= base_nxt;
      comp_cnt <= cnt_nxt;
      comp_vld <= cnt_nxt != '0;
      comp_ovf <= ovf_nxt;
    end
  end
`ifdef COMP_STATS_EN
  logic [32:0] total_sum;
  assign total_sum = {1'b0, comp_total} + 33'(comp_cnt);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comp_total <= '0;
      comp_total_ovf <= 1'b0;
    end else if (!clock_active) begin
      comp_total <= '0;
      comp_total_ovf <= 1'b0;
    end else if (comp_vld && comp_rdy) begin
      comp_total <= total_sum[31:0];
      comp_total_ovf <= comp_total_ovf | total_sum[32];
    end
  end
`endif
endmodule
